// File: rtl/dct8_transpose_buf_pkg.sv
// Shared constants, vector type and pack/unpack helpers for the 8x8 DCT transpose path.
package dct_pkg;
    localparam int unsigned DCT_N      = 8;
    localparam int unsigned DCT_IDX_W  = 3;
    localparam int unsigned DCT_DATA_W = 32;
    localparam int unsigned DCT_VEC_W  = DCT_N * DCT_DATA_W;

    typedef logic signed [DCT_DATA_W-1:0] dct_vec_t [DCT_N];

    // Lane k occupies bits [k*DCT_DATA_W +: DCT_DATA_W] of the flattened vector.
    function automatic logic [DCT_VEC_W-1:0] dct_pack(input dct_vec_t v);
        logic [DCT_VEC_W-1:0] flat;
        flat = '0;
        for (int unsigned k = 0; k < DCT_N; k++) begin
            flat[k*DCT_DATA_W +: DCT_DATA_W] = v[k];
        end
        return flat;
    endfunction

    function automatic dct_vec_t dct_unpack(input logic [DCT_VEC_W-1:0] flat);
        dct_vec_t v;
        for (int unsigned k = 0; k < DCT_N; k++) begin
            v[k] = flat[k*DCT_DATA_W +: DCT_DATA_W];
        end
        return v;
    endfunction
endpackage

// File: rtl/dct8_transpose_buf_if.sv
// Row-in / column-out stream bundle of the transpose buffer; master drives rows and consumes columns.
interface dct8_transpose_buf_if #(
    parameter int DATA_W = 32,
    parameter int N      = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [N*DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dct8_transpose_buf_bank.sv
// One 8x8 coefficient bank: whole-row write port, asynchronous whole-column read port.
module dct_tp_bank
    import dct_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [DCT_IDX_W-1:0]      row,
    input  logic [DCT_N*DATA_W-1:0]   wr_vec,
    input  logic [DCT_IDX_W-1:0]      col,
    output logic [DCT_N*DATA_W-1:0]   rd_vec
);
    logic [DATA_W-1:0] mem [DCT_N][DCT_N];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned c = 0; c < DCT_N; c++) begin
                mem[row][c] <= wr_vec[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_vec = '0;
        for (int unsigned r = 0; r < DCT_N; r++) begin
            rd_vec[r*DATA_W +: DATA_W] = mem[r][col];
        end
    end
endmodule

// File: rtl/dct8_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows written into one bank while columns are read from the other.
module dct8_transpose_buf
    import dct_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dct8_transpose_buf_if.slave  bus
);
    logic                 wr_bank;
    logic                 rd_bank;
    logic [DCT_IDX_W-1:0] row_cnt;
    logic [DCT_IDX_W-1:0] col_cnt;
    logic [1:0]           full;
    logic                 wr_fire;
    logic                 rd_fire;
    logic [N*DATA_W-1:0]  rd_vec [2];

    assign bus.in_ready  = !full[wr_bank];
    assign bus.out_valid = full[rd_bank];
    assign wr_fire       = bus.in_valid && bus.in_ready;
    assign rd_fire       = bus.out_valid && bus.out_ready;
    assign bus.out_data  = bus.out_valid ? rd_vec[rd_bank] : '0;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_tp_bank #(.DATA_W(DATA_W)) u_bank (
            .clk    (clk),
            .we     (wr_fire && (wr_bank == 1'(b))),
            .row    (row_cnt),
            .wr_vec (bus.in_data),
            .col    (col_cnt),
            .rd_vec (rd_vec[b])
        );
    end

    // Write and read may finish blocks in the same cycle; they always target different banks,
    // so the two per-bit updates of full never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            row_cnt <= '0;
            col_cnt <= '0;
            full    <= '0;
        end else begin
            if (wr_fire) begin
                row_cnt <= row_cnt + 1'b1;
                if (row_cnt == DCT_IDX_W'(N - 1)) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                col_cnt <= col_cnt + 1'b1;
                if (col_cnt == DCT_IDX_W'(N - 1)) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end
endmodule

// File: tb/tb_dct8_transpose_buf.sv
// Directed and randomized bench for dct8_transpose_buf against a block-queue transpose model.
module tb_dct8_transpose_buf;
    import dct_pkg::*;

    typedef logic [DCT_DATA_W-1:0] blk_t [64];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    dct8_transpose_buf_if #(.DATA_W(DCT_DATA_W), .N(DCT_N)) bus ();

    dct8_transpose_buf #(.DATA_W(DCT_DATA_W), .N(DCT_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: completed blocks awaiting read, the partial block being written, and the read column.
    blk_t blk_q[$];
    blk_t cur;
    int   nrows = 0;
    int   rd_col = 0;

    logic                 obs_ir;
    logic                 obs_ov;
    logic [DCT_VEC_W-1:0] obs_od;

    function automatic logic [DCT_VEC_W-1:0] col_vec(input blk_t b, input int col);
        dct_vec_t v;
        for (int k = 0; k < 8; k++) v[k] = b[k*8 + col];
        return dct_pack(v);
    endfunction

    function automatic logic [DCT_VEC_W-1:0] make_row(input int base);
        dct_vec_t v;
        for (int c = 0; c < 8; c++) v[c] = base + c;
        return dct_pack(v);
    endfunction

    function automatic logic [DCT_DATA_W-1:0] lane(input logic [DCT_VEC_W-1:0] flat, input int k);
        dct_vec_t v;
        v = dct_unpack(flat);
        return v[k];
    endfunction

    task automatic model_clear();
        blk_q.delete();
        nrows  = 0;
        rd_col = 0;
    endtask

    task automatic step(input logic iv, input logic [DCT_VEC_W-1:0] d, input logic ordy,
                        output logic acc);
        logic                 exp_ir, exp_ov, rd;
        logic [DCT_VEC_W-1:0] exp_od;
        dct_vec_t             v;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        exp_ir = (blk_q.size() < 2);
        exp_ov = (blk_q.size() > 0);
        exp_od = exp_ov ? col_vec(blk_q[0], rd_col) : '0;
        obs_ir = bus.in_ready;
        obs_ov = bus.out_valid;
        obs_od = bus.out_data;
        checks += 3;
        assert (obs_ir === exp_ir) else begin
            failures++;
            $error("FAIL in_ready got=%b exp=%b", obs_ir, exp_ir);
        end
        assert (obs_ov === exp_ov) else begin
            failures++;
            $error("FAIL out_valid got=%b exp=%b", obs_ov, exp_ov);
        end
        assert (obs_od === exp_od) else begin
            failures++;
            $error("FAIL out_data got=%h exp=%h", obs_od, exp_od);
        end
        acc = iv && exp_ir;
        rd  = exp_ov && ordy;
        @(posedge clk);
        if (acc) begin
            v = dct_unpack(d);
            for (int c = 0; c < 8; c++) cur[nrows*8 + c] = v[c];
            nrows++;
            if (nrows == 8) begin
                blk_q.push_back(cur);
                nrows = 0;
            end
        end
        if (rd) begin
            rd_col++;
            if (rd_col == 8) begin
                void'(blk_q.pop_front());
                rd_col = 0;
            end
        end
    endtask

    task automatic offer(input logic [DCT_VEC_W-1:0] d, input logic ordy, output int tries);
        logic acc;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 50) begin
            step(1'b1, d, ordy, acc);
            tries++;
        end
        checks++;
        assert (acc) else begin
            failures++;
            $error("FAIL offer_timeout got=%0d tries exp=accept", tries);
        end
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while ((blk_q.size() > 0) && n < 200) begin
            step(1'b0, '0, 1'b1, acc);
            n++;
        end
        checks++;
        assert (blk_q.size() == 0) else begin
            failures++;
            $error("FAIL drain_timeout got=%0d blocks exp=0", blk_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        model_clear();
        #1 rst = 1'b0;
    endtask

    initial begin
        logic acc;
        int   tries;
        int   accepted;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        #1 rst = 1'b0;

        // Reset state
        step(1'b0, '0, 1'b0, acc);

        // Single block: column 0 appears the cycle after row 7
        for (int r = 0; r < 8; r++) offer(make_row(r*8), 1'b1, tries);
        step(1'b0, '0, 1'b1, acc);
        checks += 3;
        assert (obs_ov === 1'b1) else begin failures++; $error("FAIL col0_valid got=%b exp=1", obs_ov); end
        assert (lane(obs_od, 1) === 32'd8) else begin failures++; $error("FAIL col0_lane1 got=%0d exp=8", lane(obs_od, 1)); end
        assert (lane(obs_od, 7) === 32'd56) else begin failures++; $error("FAIL col0_lane7 got=%0d exp=56", lane(obs_od, 7)); end
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, acc);
        checks++;
        assert (lane(obs_od, 7) === 32'd63) else begin failures++; $error("FAIL col7_lane7 got=%0d exp=63", lane(obs_od, 7)); end
        step(1'b0, '0, 1'b1, acc);
        checks++;
        assert (obs_ov === 1'b0) else begin failures++; $error("FAIL single_done_valid got=%b exp=0", obs_ov); end

        // Back-to-back: 3 blocks, every row accepted first try; block boundaries coincide with last-column reads
        for (int r = 0; r < 24; r++) begin
            offer(make_row((r / 8) * 64 + (r % 8) * 8), 1'b1, tries);
            checks++;
            assert (tries == 1) else begin failures++; $error("FAIL b2b_stall got=%0d tries exp=1", tries); end
        end
        drain();

        // Backpressure: two full banks stall row 16 until 8 columns are taken
        for (int r = 0; r < 16; r++) offer(make_row(1000 + r*8), 1'b0, tries);
        step(1'b1, make_row(2000), 1'b0, acc);
        checks++;
        assert (obs_ir === 1'b0) else begin failures++; $error("FAIL bp_ready got=%b exp=0", obs_ir); end
        offer(make_row(2000), 1'b1, tries);
        checks++;
        assert (tries == 9) else begin failures++; $error("FAIL bp_release got=%0d tries exp=9", tries); end
        for (int r = 1; r < 8; r++) offer(make_row(2000 + r*8), 1'b1, tries);
        drain();

        // Random gaps over 20 blocks
        accepted = 0;
        for (int n = 0; n < 5000 && accepted < 160; n++) begin
            step(1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), acc);
            if (acc) accepted++;
        end
        checks++;
        assert (accepted == 160) else begin failures++; $error("FAIL random_rows got=%0d exp=160", accepted); end
        drain();

        // Reset mid-block while the previous block is being read
        for (int r = 0; r < 8; r++) offer(make_row(3000 + r*8), 1'b0, tries);
        for (int r = 0; r < 5; r++) offer(make_row(4000 + r*8), 1'b1, tries);
        do_reset();
        step(1'b0, '0, 1'b1, acc);
        checks += 2;
        assert (obs_ov === 1'b0) else begin failures++; $error("FAIL rst_valid got=%b exp=0", obs_ov); end
        assert (obs_ir === 1'b1) else begin failures++; $error("FAIL rst_ready got=%b exp=1", obs_ir); end
        for (int r = 0; r < 8; r++) offer(make_row(5000 + r*8), 1'b1, tries);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dct8_transpose_buf.md
Name: dct8_transpose_buf

Overview:
- Ping-pong 8x8 transpose buffer between the row-pass and column-pass dct8_chen_ts instances of the 2D 8x8 DCT.
- Accepts eight row-DCT output vectors, one per handshake, and emits the transposed block as eight column vectors.
- Two banks allow the next block to be written while the current one is read, giving full throughput of one vector per cycle.

Parameters:
- DATA_W, 32, width of each coefficient lane (matches the DCT IN_W).
- N, 8, block dimension. Fixed at 8; other values are unsupported.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  row vector valid.
- in_ready  out  1  buffer can accept a row.
- in_data  in  N*DATA_W  row vector; lane k at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  column vector valid.
- out_ready  in  1  downstream accepts a column.
- out_data  out  N*DATA_W  column vector; lane k = element at row k of the current column.

Behaviour:
- State: two banks mem[b][r][c]; wr_bank, rd_bank (1 bit each); row_cnt, col_cnt (3 bits each); full[1:0].
- Write side:
  - in_ready = !full[wr_bank].
  - On in_valid && in_ready: mem[wr_bank][row_cnt][k] <= lane k; row_cnt++.
  - When row_cnt==7: set full[wr_bank], toggle wr_bank, row_cnt wraps to 0.
  - in_valid with in_ready=0: ignored, no state change.
- Read side:
  - out_valid = full[rd_bank].
  - out_data lane k = mem[rd_bank][k][col_cnt] when out_valid=1; all zero otherwise.
  - On out_valid && out_ready: col_cnt++.
  - When col_cnt==7: clear full[rd_bank], toggle rd_bank, col_cnt wraps to 0.
- Latency: column 0 is valid the cycle after the 8th row handshake.
- Throughput: with out_ready=1, one vector per cycle sustained; in_ready never deasserts.
- Simultaneous events:
  - Last-row write to bank A and last-column read of bank B in the same cycle: both take effect. full[A] is set, full[B] is cleared.
  - If A==B, this is only possible when full[A]=0, i.e. no read is pending on A, so there is no conflict.
  - A write to a bank never coincides with a read of the same bank.
- Full condition: both banks full means in_ready=0 until the first read-bank release. in_ready rises the cycle after the 8th column handshake.
- Empty condition: out_valid=0, out_data=0. out_ready is ignored.
- Arithmetic: none. Data passes bit-exact; lanes are treated as opaque signed values.
- Reset:
  - rst=1 clears wr_bank, rd_bank, row_cnt, col_cnt and full.
  - After reset: in_ready=1, out_valid=0, out_data=0.
  - Bank storage is not reset.
  - Reset mid-block discards partial and full blocks; the next accepted row is row 0 of bank 0.
- No combinational path from in_valid to in_ready. out_ready affects only registered state.

Decomposition:
- Package dct_pkg holds:
  - constants DCT_N=8 and DCT_IDX_W=3;
  - typedef dct_vec_t, an array of DCT_N words of DATA_W (default 32);
  - helper functions for packing and unpacking the flattened vector.
- Sub-module dct_tp_bank: one 8x8 register bank with a row-write port (we, row, vector) and a column-read port (col, vector). Instantiated twice; the top module holds the counters, bank pointers and full flags.

Test Plan:
- Single block: row r lane c = r*8+c, out_ready=1 → column 0 appears the cycle after row 7 with lanes 0,8,16,...,56; column 7 = 7,15,...,63; out_valid low afterwards.
- Back-to-back: 3 blocks, 24 rows on consecutive cycles, out_ready=1 → in_ready stays 1; 24 columns on consecutive cycles from cycle 9; block b lanes offset by b*64.
- Backpressure: out_ready=0, 17 rows offered → in_ready falls after row 16. Row 17 is held and not accepted. Then out_ready=1 → in_ready returns one cycle after the 8th column handshake, and row 17 lands as row 0 of the freed bank.
- Random gaps: random in_valid and out_ready at 50% duty over 20 blocks → output equals the scoreboarded transpose; no loss or duplication.
- Simultaneous boundary: last-row write of block 1 and last-column read of block 0 in the same cycle → out_valid stays 1 and column 0 of block 1 is output the next cycle.
- Reset mid-block: rst=1 for one cycle after 5 rows of block 1 while block 0 is being read → out_valid=0 and in_ready=1 the next cycle; a fresh block then transposes correctly.
